// File: rtl/rpspmc_axis_pkg.sv
// Shared AXIS word layout for the two-channel ADC path: channel half selection,
// widths and the signed 16-bit saturation used after offset removal.
package rpspmc_axis_pkg;

  localparam int ADC_WIDTH        = 14;
  localparam int AXIS_DATA_WIDTH  = 16;
  localparam int AXIS_TDATA_WIDTH = 2 * AXIS_DATA_WIDTH;
  localparam int DEC_LOG2_MAX     = 4;
  localparam int ACC_WIDTH        = AXIS_DATA_WIDTH + DEC_LOG2_MAX;
  localparam int S16_MAX          = 32767;
  localparam int S16_MIN          = -32768;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ACCUM = 1'b1
  } blk_state_t;

  function automatic logic [AXIS_DATA_WIDTH-1:0] upper_half(input logic [AXIS_TDATA_WIDTH-1:0] w);
    return w[AXIS_TDATA_WIDTH-1 -: AXIS_DATA_WIDTH];
  endfunction

  function automatic logic [AXIS_DATA_WIDTH-1:0] lower_half(input logic [AXIS_TDATA_WIDTH-1:0] w);
    return w[AXIS_DATA_WIDTH-1:0];
  endfunction

  // Input carries two guard bits so the raw difference never wraps.
  function automatic logic signed [AXIS_DATA_WIDTH-1:0] sat_s16(input logic signed [AXIS_DATA_WIDTH+1:0] x);
    if (x > S16_MAX)      return AXIS_DATA_WIDTH'(S16_MAX);
    else if (x < S16_MIN) return AXIS_DATA_WIDTH'(S16_MIN);
    else                  return AXIS_DATA_WIDTH'(x);
  endfunction

  function automatic logic is_sat_s16(input logic signed [AXIS_DATA_WIDTH+1:0] x);
    return (x > S16_MAX) || (x < S16_MIN);
  endfunction

endpackage

// File: rtl/adc_dual_channel_decimator_if.sv
// AXI-Stream style handshake bundle used for the packed ADC input and the decimated output.
interface adc_dual_channel_decimator_if
  #(parameter int DATA_W = rpspmc_axis_pkg::AXIS_TDATA_WIDTH);

  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);

endinterface

// File: rtl/adc_channel_accum.sv
// One channel: sign-extend the ADC field, remove the offset with saturation,
// and accumulate a block; mean is the floor-shifted block sum including this sample.
module adc_channel_accum #(
  parameter int ADC_W   = rpspmc_axis_pkg::ADC_WIDTH,
  parameter int DATA_W  = rpspmc_axis_pkg::AXIS_DATA_WIDTH,
  parameter int ACC_W   = rpspmc_axis_pkg::ACC_WIDTH,
  parameter int SHIFT_W = 3
) (
  input  logic                     adc_clk,
  input  logic                     adc_rst,
  input  logic                     clear,
  input  logic                     accept,
  input  logic                     last_sample,
  input  logic [DATA_W-1:0]        sample_half,
  input  logic signed [DATA_W-1:0] offset,
  input  logic [SHIFT_W-1:0]       shift,
  output logic                     sat,
  output logic [DATA_W-1:0]        mean
);
  import rpspmc_axis_pkg::*;

  logic signed [DATA_W+1:0] ch_ext;
  logic signed [DATA_W+1:0] diff;
  logic signed [DATA_W-1:0] d;
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  sum;
  logic signed [ACC_W-1:0]  scaled;
  logic                     unused_guard;

  // Bits above the ADC field are padding in the packed word.
  assign unused_guard = ^sample_half[DATA_W-1:ADC_W];

  assign ch_ext = {{(DATA_W+2-ADC_W){sample_half[ADC_W-1]}}, sample_half[ADC_W-1:0]};
  assign diff   = ch_ext - (DATA_W+2)'(offset);
  assign d      = sat_s16(diff);
  assign sat    = is_sat_s16(diff);
  assign sum    = acc + ACC_W'(d);
  assign scaled = sum >>> shift;
  assign mean   = DATA_W'(scaled);

  always_ff @(posedge adc_clk) begin
    if (adc_rst || clear) begin
      acc <= '0;
    end else if (accept) begin
      acc <= last_sample ? '0 : sum;
    end
  end

endmodule

// File: rtl/adc_dual_channel_decimator.sv
// Two-channel block-averaging decimator: unpacks the packed ADC word, removes
// per-channel offsets and emits one packed mean per 2^shift accepted samples.
//
//   state    | meaning
//   ST_IDLE  | block logic cleared; latches shift when enable is high
//   ST_ACCUM | accumulating; block end reloads output and re-latches shift
module adc_dual_channel_decimator #(
  parameter int ADC_WIDTH        = rpspmc_axis_pkg::ADC_WIDTH,
  parameter int AXIS_DATA_WIDTH  = rpspmc_axis_pkg::AXIS_DATA_WIDTH,
  parameter int AXIS_TDATA_WIDTH = rpspmc_axis_pkg::AXIS_TDATA_WIDTH,
  parameter int DEC_LOG2_MAX     = rpspmc_axis_pkg::DEC_LOG2_MAX
) (
  input  logic                              adc_clk,
  input  logic                              adc_rst,
  input  logic                              enable,
  input  logic [2:0]                        dec_log2,
  input  logic signed [AXIS_DATA_WIDTH-1:0] offset_ch1,
  input  logic signed [AXIS_DATA_WIDTH-1:0] offset_ch2,
  adc_dual_channel_decimator_if.slave       s_axis,
  adc_dual_channel_decimator_if.master      m_axis,
  output logic                              sat_flag,
  output logic [15:0]                       drop_count
);
  import rpspmc_axis_pkg::*;

  localparam int ACC_W = AXIS_DATA_WIDTH + DEC_LOG2_MAX;

  blk_state_t                  state_q, state_d;
  logic [2:0]                  shift_q;
  logic [2:0]                  shift_clamped;
  logic [DEC_LOG2_MAX-1:0]     cnt_q;
  logic [DEC_LOG2_MAX-1:0]     last_cnt;
  logic                        at_last;
  logic                        s_ready;
  logic                        accept;
  logic                        final_smp;
  logic                        clear_blk;
  logic                        sat_ch1, sat_ch2;
  logic [AXIS_DATA_WIDTH-1:0]  mean_ch1, mean_ch2;
  logic                        m_valid_q;
  logic [AXIS_TDATA_WIDTH-1:0] m_data_q;

  assign shift_clamped = (int'(dec_log2) > DEC_LOG2_MAX) ? 3'(DEC_LOG2_MAX) : dec_log2;
  assign last_cnt      = DEC_LOG2_MAX'((1 << shift_q) - 1);
  assign at_last       = (cnt_q == last_cnt);

  // Only the block's final sample needs the output register free.
  assign s_ready   = enable && (state_q == ST_ACCUM) && !(at_last && m_valid_q && !m_axis.tready);
  assign accept    = s_axis.tvalid && s_ready;
  assign final_smp = accept && at_last;
  assign clear_blk = (state_q == ST_IDLE) || !enable;

  assign s_axis.tready = s_ready;
  assign m_axis.tvalid = m_valid_q;
  assign m_axis.tdata  = m_data_q;

  always_ff @(posedge adc_clk) begin
    if (adc_rst) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (enable)  state_d = ST_ACCUM;
      ST_ACCUM: if (!enable) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge adc_clk) begin
    if (adc_rst) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else if (state_q == ST_IDLE) begin
      cnt_q <= '0;
      if (enable) shift_q <= shift_clamped;
    end else if (!enable) begin
      cnt_q <= '0;
    end else if (final_smp) begin
      cnt_q   <= '0;
      shift_q <= shift_clamped;
    end else if (accept) begin
      cnt_q <= cnt_q + DEC_LOG2_MAX'(1);
    end
  end

  adc_channel_accum #(
    .ADC_W(ADC_WIDTH), .DATA_W(AXIS_DATA_WIDTH), .ACC_W(ACC_W), .SHIFT_W(3)
  ) u_ch1 (
    .adc_clk(adc_clk), .adc_rst(adc_rst), .clear(clear_blk), .accept(accept),
    .last_sample(at_last), .sample_half(upper_half(s_axis.tdata)), .offset(offset_ch1),
    .shift(shift_q), .sat(sat_ch1), .mean(mean_ch1)
  );

  adc_channel_accum #(
    .ADC_W(ADC_WIDTH), .DATA_W(AXIS_DATA_WIDTH), .ACC_W(ACC_W), .SHIFT_W(3)
  ) u_ch2 (
    .adc_clk(adc_clk), .adc_rst(adc_rst), .clear(clear_blk), .accept(accept),
    .last_sample(at_last), .sample_half(lower_half(s_axis.tdata)), .offset(offset_ch2),
    .shift(shift_q), .sat(sat_ch2), .mean(mean_ch2)
  );

  // Reload has priority so a drain and a new word can share one cycle.
  always_ff @(posedge adc_clk) begin
    if (adc_rst) begin
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
    end else if (final_smp) begin
      m_valid_q <= 1'b1;
      m_data_q  <= {mean_ch1, mean_ch2};
    end else if (m_valid_q && m_axis.tready) begin
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
    end
  end

  always_ff @(posedge adc_clk) begin
    if (adc_rst) begin
      sat_flag   <= 1'b0;
      drop_count <= '0;
    end else begin
      if (accept && (sat_ch1 || sat_ch2)) sat_flag <= 1'b1;
      if (s_axis.tvalid && !s_ready && (drop_count != 16'hFFFF)) drop_count <= drop_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_adc_dual_channel_decimator.sv
// Directed and randomized checks of the dual-channel decimator against a
// sample-list reference model with a scoreboard queue of expected output words.
module tb_adc_dual_channel_decimator;
  import rpspmc_axis_pkg::*;

  logic               adc_clk = 1'b0;
  logic               adc_rst = 1'b1;
  logic               enable = 1'b0;
  logic [2:0]         dec_log2 = 3'd0;
  logic signed [15:0] offset_ch1 = 16'sd0;
  logic signed [15:0] offset_ch2 = 16'sd0;
  logic               sat_flag;
  logic [15:0]        drop_count;

  adc_dual_channel_decimator_if #(.DATA_W(AXIS_TDATA_WIDTH)) s_axis ();
  adc_dual_channel_decimator_if #(.DATA_W(AXIS_TDATA_WIDTH)) m_axis ();

  always #5 adc_clk = ~adc_clk;

  adc_dual_channel_decimator dut (
    .adc_clk(adc_clk), .adc_rst(adc_rst), .enable(enable), .dec_log2(dec_log2),
    .offset_ch1(offset_ch1), .offset_ch2(offset_ch2),
    .s_axis(s_axis), .m_axis(m_axis),
    .sat_flag(sat_flag), .drop_count(drop_count)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Reference model: block bookkeeping in plain integers.
  logic [31:0] exp_q[$];
  bit          mdl_idle = 1;
  int          mdl_shift = 0;
  int          mdl_n = 0;
  int          mdl_sum1 = 0, mdl_sum2 = 0;
  bit          mdl_sat = 0;
  int          mdl_drop = 0;
  int          n_out = 0;
  int          md1, md2;
  logic        exp_ready;
  logic [31:0] obs_word;

  function automatic int clamp_dl(input logic [2:0] dl);
    return (int'(dl) > 4) ? 4 : int'(dl);
  endfunction

  function automatic int adc_val(input logic [15:0] h);
    int v;
    v = int'(h[13:0]);
    if (v >= 8192) v = v - 16384;
    return v;
  endfunction

  function automatic int floor_div(input int s, input int n);
    if (s >= 0) return s / n;
    return -((-s + n - 1) / n);
  endfunction

  always @(negedge adc_clk) begin
    if (adc_rst) begin
      exp_q.delete();
      mdl_idle = 1; mdl_n = 0; mdl_sum1 = 0; mdl_sum2 = 0;
      mdl_sat = 0; mdl_drop = 0;
    end else begin
      if (m_axis.tvalid && m_axis.tready) begin
        n_out++;
        obs_word = m_axis.tdata;
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_output actual=%h required=none", obs_word);
        end else begin
          chk("out_word", obs_word, exp_q.pop_front());
        end
      end
      exp_ready = enable && !mdl_idle &&
                  !((mdl_n == (1 << mdl_shift) - 1) && m_axis.tvalid && !m_axis.tready);
      chk("s_tready", 32'(s_axis.tready), 32'(exp_ready));
      if (s_axis.tvalid && !s_axis.tready && mdl_drop < 65535) mdl_drop++;
      if (!enable) begin
        mdl_idle = 1; mdl_n = 0; mdl_sum1 = 0; mdl_sum2 = 0;
      end else if (mdl_idle) begin
        mdl_idle = 0;
        mdl_shift = clamp_dl(dec_log2);
      end else if (s_axis.tvalid && s_axis.tready) begin
        md1 = adc_val(s_axis.tdata[31:16]) - int'(offset_ch1);
        md2 = adc_val(s_axis.tdata[15:0]) - int'(offset_ch2);
        if (md1 > 32767) begin md1 = 32767; mdl_sat = 1; end
        if (md1 < -32768) begin md1 = -32768; mdl_sat = 1; end
        if (md2 > 32767) begin md2 = 32767; mdl_sat = 1; end
        if (md2 < -32768) begin md2 = -32768; mdl_sat = 1; end
        mdl_sum1 += md1; mdl_sum2 += md2; mdl_n++;
        if (mdl_n == (1 << mdl_shift)) begin
          exp_q.push_back({16'(floor_div(mdl_sum1, 1 << mdl_shift)),
                           16'(floor_div(mdl_sum2, 1 << mdl_shift))});
          mdl_n = 0; mdl_sum1 = 0; mdl_sum2 = 0;
          mdl_shift = clamp_dl(dec_log2);
        end
      end
    end
  end

  task automatic tick();
    @(posedge adc_clk); #1;
  endtask

  task automatic send(input logic [31:0] w);
    bit done;
    done = 0;
    s_axis.tdata = w;
    s_axis.tvalid = 1'b1;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge adc_clk);
      if (s_axis.tready) done = 1;
      @(posedge adc_clk); #1;
    end
    s_axis.tvalid = 1'b0;
    chk("send_accepted", 32'(done), 32'd1);
  endtask

  task automatic restart(input logic [2:0] dl);
    s_axis.tvalid = 1'b0;
    enable = 1'b0;
    dec_log2 = dl;
    tick();
    enable = 1'b1;
    tick();
  endtask

  initial begin
    int n0;
    logic [31:0] w;
    s_axis.tdata = '0;
    s_axis.tvalid = 1'b0;
    m_axis.tready = 1'b1;
    adc_rst = 1'b1;
    tick(); tick();
    chk("rst_m_tvalid", 32'(m_axis.tvalid), 32'd0);
    chk("rst_m_tdata", m_axis.tdata, 32'd0);
    chk("rst_s_tready", 32'(s_axis.tready), 32'd0);
    chk("rst_sat", 32'(sat_flag), 32'd0);
    chk("rst_drop", 32'(drop_count), 32'd0);
    adc_rst = 1'b0;

    // Single-sample blocks
    restart(3'd0);
    chk("t1_pre_valid", 32'(m_axis.tvalid), 32'd0);
    send(32'h1FFF_2000);
    chk("t1_valid", 32'(m_axis.tvalid), 32'd1);
    chk("t1_data", m_axis.tdata, 32'h1FFF_E000);
    chk("t1_sat", 32'(sat_flag), 32'd0);

    // Four-sample block with floor rounding
    restart(3'd2);
    n0 = n_out;
    send(32'h0001_FFFF); send(32'h0002_FFFF); send(32'h0003_FFFF);
    chk("t2_no_early", 32'(m_axis.tvalid), 32'd0);
    send(32'h0005_FFFE);
    chk("t2_valid", 32'(m_axis.tvalid), 32'd1);
    chk("t2_data", m_axis.tdata, 32'h0002_FFFE);
    tick(); tick();
    chk("t2_one_word", 32'(n_out - n0), 32'd1);

    // Offset subtraction and saturation
    offset_ch1 = 16'sh7FFF;
    offset_ch2 = -16'sd100;
    restart(3'd0);
    send(32'h2000_0000);
    chk("t3_data", m_axis.tdata, 32'h8000_0064);
    chk("t3_sat", 32'(sat_flag), 32'd1);
    offset_ch1 = 16'sd0;
    offset_ch2 = 16'sd0;

    // Backpressure: hold, stall input, count drops, then drain and reload together
    restart(3'd0);
    chk("t4_drop_pre", 32'(drop_count), 32'd0);
    m_axis.tready = 1'b0;
    send(32'h0010_0020);
    chk("t4_first", m_axis.tdata, 32'h0010_0020);
    s_axis.tdata = 32'h0030_0040;
    s_axis.tvalid = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge adc_clk);
      chk("t4_stall_ready", 32'(s_axis.tready), 32'd0);
      chk("t4_hold_data", m_axis.tdata, 32'h0010_0020);
      chk("t4_hold_valid", 32'(m_axis.tvalid), 32'd1);
      tick();
      chk("t4_drop", 32'(drop_count), 32'(k));
    end
    m_axis.tready = 1'b1;
    @(negedge adc_clk);
    chk("t4_resume_ready", 32'(s_axis.tready), 32'd1);
    tick();
    s_axis.tvalid = 1'b0;
    chk("t4_reload_valid", 32'(m_axis.tvalid), 32'd1);
    chk("t4_reload_data", m_axis.tdata, 32'h0030_0040);
    chk("t4_sat_sticky", 32'(sat_flag), 32'd1);

    // Reset in the middle of a block
    restart(3'd3);
    for (int i = 0; i < 5; i++) send(32'h03E8_03E8);
    adc_rst = 1'b1;
    tick();
    chk("t5_rst_valid", 32'(m_axis.tvalid), 32'd0);
    chk("t5_rst_ready", 32'(s_axis.tready), 32'd0);
    chk("t5_rst_drop", 32'(drop_count), 32'd0);
    chk("t5_rst_sat", 32'(sat_flag), 32'd0);
    adc_rst = 1'b0;
    tick();
    for (int i = 0; i < 7; i++) send(32'h0004_0004);
    chk("t5_no_early", 32'(m_axis.tvalid), 32'd0);
    send(32'h0004_0004);
    chk("t5_data", m_axis.tdata, 32'h0004_0004);
    chk("t5_drop", 32'(drop_count), 32'd0);

    // dec_log2 change mid-block only applies at the next block
    restart(3'd1);
    send(32'h000A_FFFD);
    dec_log2 = 3'd3;
    send(32'h0014_FFFC);
    chk("t6_blk2_valid", 32'(m_axis.tvalid), 32'd1);
    chk("t6_blk2_data", m_axis.tdata, 32'h000F_FFFC);
    for (int i = 0; i < 7; i++) begin
      w = {16'(i), 16'(-i)};
      send(w);
    end
    chk("t6_no_early", 32'(m_axis.tvalid), 32'd0);
    send({16'd7, 16'hFFF9});
    chk("t6_blk8_data", m_axis.tdata, 32'h0003_FFFC);

    // enable drop discards the partial block; valid in IDLE counts as drops
    restart(3'd2);
    send(32'h0100_0100); send(32'h0100_0100);
    enable = 1'b0;
    tick();
    chk("t7_idle_ready", 32'(s_axis.tready), 32'd0);
    s_axis.tvalid = 1'b1;
    tick(); tick();
    s_axis.tvalid = 1'b0;
    chk("t7_drop", 32'(drop_count), 32'd2);
    enable = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) send(32'h0008_0008);
    chk("t7_data", m_axis.tdata, 32'h0008_0008);

    // Randomized traffic against the reference model
    adc_rst = 1'b1;
    tick();
    adc_rst = 1'b0;
    dec_log2 = 3'($urandom_range(0, 7));
    enable = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      s_axis.tvalid = ($urandom_range(0, 9) < 7);
      s_axis.tdata = $urandom;
      m_axis.tready = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 19) == 0) dec_log2 = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 49) == 0) begin
        if ($urandom_range(0, 3) == 0) offset_ch1 = 16'($urandom);
        else offset_ch1 = 16'($urandom_range(0, 400) - 200);
        offset_ch2 = 16'($urandom_range(0, 400) - 200);
      end
      enable = ($urandom_range(0, 99) != 0);
      tick();
    end
    s_axis.tvalid = 1'b0;
    m_axis.tready = 1'b1;
    enable = 1'b1;
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) tick();
    tick();
    chk("rand_drained", 32'(exp_q.size()), 32'd0);
    chk("rand_sat", 32'(sat_flag), 32'(mdl_sat));
    chk("rand_drop", 32'(drop_count), 32'(mdl_drop));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
